nc_mac_engine: RTL and testbench

Parametrised successor to the single-product multiplier behind the chip's UART and MULT_DONE pins. It takes a byte stream, typically from the UART receiver, and performs a LANES-wide vector multiply-accumulate (dot products) with selectable signed, unsigned or ReLU mode and saturating accumulators. Results return as a byte stream for the UART transmitter, and a one-cycle DONE pulse replaces MULT_DONE.

---
 rtl/nc_pkg.sv | 36 +++
 rtl/nc_mac_lane_sat.sv | 47 ++++
 rtl/nc_mac_engine.sv | 147 ++++++++++++++
 tb/tb_nc_mac_engine.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nc_pkg.sv
// Shared definitions for the vector MAC engine: mode encodings, FSM states,
// header field positions and accumulator saturation bounds.
package nc_pkg;

    localparam logic [1:0] MODE_SMAC = 2'b00;  // signed multiply-accumulate
    localparam logic [1:0] MODE_UMAC = 2'b01;  // unsigned multiply-accumulate
    localparam logic [1:0] MODE_RELU = 2'b10;  // signed MAC, negative lanes read as 0
    localparam logic [1:0] MODE_RSVD = 2'b11;  // reserved, rejected with ERR

    typedef enum logic [1:0] {
        IDLE,
        ACT,
        WGT,
        OUT
    } state_t;

    // Header byte layout: mode in the top two bits, length in the low bits.
    localparam int HDR_MODE_HI = 7;
    localparam int HDR_MODE_LO = 6;

    // Largest signed accumulator value, as an acc_w-bit pattern in the low bits.
    function automatic logic [31:0] sat_smax(input int acc_w);
        return (32'h1 << (acc_w - 1)) - 32'h1;
    endfunction

    // Most negative signed accumulator value, as an acc_w-bit pattern.
    function automatic logic [31:0] sat_smin(input int acc_w);
        return 32'h1 << (acc_w - 1);
    endfunction

    // Largest unsigned accumulator value.
    function automatic logic [31:0] sat_umax(input int acc_w);
        return (acc_w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << acc_w) - 32'h1);
    endfunction

endpackage

// File: rtl/nc_mac_lane_sat.sv
// One 8x8 multiply plus accumulator add with saturation. Combinational; the
// engine shares a single instance across all lanes.
module nc_mac_lane_sat
    import nc_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0] acc_in,
    input  logic [7:0]       a,
    input  logic [7:0]       w,
    input  logic             is_signed,
    output logic [ACC_W-1:0] acc_out
);

    // One guard bit above the accumulator is enough to detect overflow,
    // because a single 16-bit product never exceeds the accumulator range.
    localparam int EW = ACC_W + 1;
    localparam logic [ACC_W-1:0] SMAX = ACC_W'(sat_smax(ACC_W));
    localparam logic [ACC_W-1:0] SMIN = ACC_W'(sat_smin(ACC_W));
    localparam logic [ACC_W-1:0] UMAX = ACC_W'(sat_umax(ACC_W));

    logic signed [15:0]   prod_s;
    logic [15:0]          prod_u;
    logic signed [EW-1:0] sum_s;
    logic [EW-1:0]        sum_u;

    // Form both signed and unsigned sums, then clamp the selected one.
    always_comb begin
        prod_s  = $signed({{8{a[7]}}, a}) * $signed({{8{w[7]}}, w});
        prod_u  = {8'b0, a} * {8'b0, w};
        sum_s   = $signed({acc_in[ACC_W-1], acc_in}) + $signed({{(EW-16){prod_s[15]}}, prod_s});
        sum_u   = {1'b0, acc_in} + {{(EW-16){1'b0}}, prod_u};
        acc_out = sum_u[ACC_W-1:0];
        if (is_signed) begin
            if (sum_s[EW-1] && !sum_s[EW-2]) begin
                acc_out = SMIN;
            end else if (!sum_s[EW-1] && sum_s[EW-2]) begin
                acc_out = SMAX;
            end else begin
                acc_out = sum_s[ACC_W-1:0];
            end
        end else if (sum_u[EW-1]) begin
            acc_out = UMAX;
        end
    end

endmodule

// File: rtl/nc_mac_engine.sv
// Byte-stream vector multiply-accumulate engine: header, then LEN steps of one
// activation byte followed by LANES weight bytes; results stream out MSB first.
module nc_mac_engine
    import nc_pkg::*;
#(
    parameter int LANES = 4,
    parameter int ACC_W = 24,
    parameter int LEN_W = 6
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] IN_DATA,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic [7:0] OUT_DATA,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    localparam int BYTES  = ACC_W / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_t                 state_reg, state_next;
    logic [1:0]             mode_reg;
    logic [LEN_W:0]         remain_reg;
    logic [7:0]             act_reg;
    logic [LANE_W-1:0]      lane_reg;
    logic [LANE_W-1:0]      olane_reg;
    logic [1:0]             obyte_reg;
    logic [ACC_W-1:0]       acc_reg [LANES];
    logic                   done_reg;
    logic                   err_reg;

    logic                   in_accept;
    logic                   out_accept;
    logic                   last_lane;
    logic                   last_out;
    logic [LEN_W-1:0]       hdr_len;
    logic [1:0]             hdr_mode;
    logic [ACC_W-1:0]       mac_out;
    logic [ACC_W-1:0]       lane_out [LANES];
    logic [ACC_W-1:0]       out_shift;

    assign IN_READY   = (state_reg != OUT) && !RESET;
    assign OUT_VALID  = (state_reg == OUT) && !RESET;
    assign BUSY       = (state_reg != IDLE) && !RESET;
    assign DONE       = done_reg;
    assign ERR        = err_reg;
    assign in_accept  = IN_VALID && IN_READY;
    assign out_accept = OUT_VALID && OUT_READY;
    assign last_lane  = (lane_reg == LANE_W'(LANES - 1));
    assign last_out   = (olane_reg == LANE_W'(LANES - 1)) && (obyte_reg == 2'd0);
    assign hdr_len    = IN_DATA[LEN_W-1:0];
    assign hdr_mode   = IN_DATA[HDR_MODE_HI:HDR_MODE_LO];

    nc_mac_lane_sat #(.ACC_W(ACC_W)) u_mac (
        .acc_in    (acc_reg[lane_reg]),
        .a         (act_reg),
        .w         (IN_DATA),
        .is_signed (mode_reg != MODE_UMAC),
        .acc_out   (mac_out)
    );

    // ReLU masks negative lanes on the way out without touching the accumulator.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : gen_relu
            assign lane_out[gi] = (mode_reg == MODE_RELU && acc_reg[gi][ACC_W-1]) ? '0 : acc_reg[gi];
        end
    endgenerate

    // Select the current output byte: lane by olane_reg, byte within lane by obyte_reg.
    always_comb begin
        out_shift = lane_out[olane_reg] >> {obyte_reg, 3'b000};
        OUT_DATA  = OUT_VALID ? out_shift[7:0] : 8'h00;
    end

    // Next-state logic driven by accepted bytes.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_accept && hdr_mode != MODE_RSVD) state_next = ACT;
            ACT:  if (in_accept) state_next = WGT;
            WGT:  if (in_accept && last_lane) begin
                      state_next = (remain_reg == (LEN_W+1)'(1)) ? OUT : ACT;
                  end
            OUT:  if (out_accept && last_out) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, accumulators, counters and the DONE/ERR pulses.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg  <= IDLE;
            mode_reg   <= MODE_SMAC;
            remain_reg <= '0;
            act_reg    <= '0;
            lane_reg   <= '0;
            olane_reg  <= '0;
            obyte_reg  <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            for (int i = 0; i < LANES; i++) acc_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            case (state_reg)
                IDLE: if (in_accept) begin
                    for (int i = 0; i < LANES; i++) acc_reg[i] <= '0;
                    mode_reg   <= hdr_mode;
                    remain_reg <= (hdr_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, hdr_len};
                    err_reg    <= (hdr_mode == MODE_RSVD);
                end
                ACT: if (in_accept) begin
                    act_reg  <= IN_DATA;
                    lane_reg <= '0;
                end
                WGT: if (in_accept) begin
                    acc_reg[lane_reg] <= mac_out;
                    if (last_lane) begin
                        remain_reg <= remain_reg - 1'b1;
                        olane_reg  <= '0;
                        obyte_reg  <= 2'(BYTES - 1);
                    end else begin
                        lane_reg <= lane_reg + 1'b1;
                    end
                end
                OUT: if (out_accept) begin
                    if (last_out) begin
                        done_reg <= 1'b1;
                    end else if (obyte_reg == 2'd0) begin
                        olane_reg <= olane_reg + 1'b1;
                        obyte_reg <= 2'(BYTES - 1);
                    end else begin
                        obyte_reg <= obyte_reg - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nc_mac_engine.sv
// Bench for nc_mac_engine: directed and random transactions checked against a
// dot-product model with clamping, plus handshake, error and reset cases.
module tb_nc_mac_engine;

    localparam int LANES = 4;
    localparam int ACC_W = 16;
    localparam int LEN_W = 6;
    localparam int NB    = LANES * ACC_W / 8;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] IN_DATA;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] OUT_DATA;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic       BUSY;
    logic       DONE;
    logic       ERR;

    nc_mac_engine #(.LANES(LANES), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    logic [7:0] act_q[$];
    logic [7:0] wgt_q[$];
    logic [7:0] exp_q[$];

    always @(posedge CLK) if (DONE === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        act_q.delete();
        wgt_q.delete();
    endtask

    task automatic push_step(input int a, input int w0, input int w1, input int w2, input int w3);
        act_q.push_back(8'(a));
        wgt_q.push_back(8'(w0));
        wgt_q.push_back(8'(w1));
        wgt_q.push_back(8'(w2));
        wgt_q.push_back(8'(w3));
    endtask

    // Dot product per lane with clamping after every step; result bytes MSB first.
    task automatic model(input logic [1:0] mode, output longint acc0);
        longint acc, hi, lo, av, wv, v;
        logic [ACC_W-1:0] bits;
        exp_q.delete();
        hi = (mode == 2'b01) ? (64'sd1 <<< ACC_W) - 1 : (64'sd1 <<< (ACC_W - 1)) - 1;
        lo = (mode == 2'b01) ? 0 : -(64'sd1 <<< (ACC_W - 1));
        acc0 = 0;
        for (int l = 0; l < LANES; l++) begin
            acc = 0;
            for (int s = 0; s < act_q.size(); s++) begin
                if (mode == 2'b01) begin
                    av = longint'(act_q[s]);
                    wv = longint'(wgt_q[s*LANES+l]);
                end else begin
                    av = longint'($signed(act_q[s]));
                    wv = longint'($signed(wgt_q[s*LANES+l]));
                end
                acc = acc + av * wv;
                if (acc > hi) acc = hi;
                if (acc < lo) acc = lo;
            end
            if (l == 0) acc0 = acc;
            v = (mode == 2'b10 && acc < 0) ? 0 : acc;
            bits = ACC_W'(v);
            for (int b = ACC_W / 8 - 1; b >= 0; b--) exp_q.push_back(bits[b*8 +: 8]);
        end
    endtask

    // Offer one byte, optionally after a few idle cycles; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int  n;
        bit  rdy;
        if (gaps && $urandom_range(0, 2) == 0) begin
            IN_VALID = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge CLK);
            #1;
        end
        IN_DATA  = b;
        IN_VALID = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            rdy = IN_READY;
            @(posedge CLK);
            #1;
            n++;
        end while (!rdy && n < 100);
        if (!rdy) check("send_timeout", 64'(n), 64'd0);
        IN_VALID = 1'b0;
    endtask

    // Full transaction: header, body from the queues, result stream and DONE pulse.
    task automatic run_txn(input string name, input logic [7:0] hdr, input bit gaps, input bit stall);
        int     i, guard, stall_cnt, d0;
        longint acc0;
        model(hdr[7:6], acc0);
        d0 = done_cnt;
        send_byte(hdr, gaps);
        for (int s = 0; s < act_q.size(); s++) begin
            send_byte(act_q[s], gaps);
            for (int l = 0; l < LANES; l++) send_byte(wgt_q[s*LANES+l], gaps);
        end
        check({name, "_first_valid"}, 64'(OUT_VALID), 64'd1);
        i = 0;
        guard = 0;
        stall_cnt = 0;
        OUT_READY = 1'b1;
        while (i < NB && guard < 2000) begin
            guard++;
            @(negedge CLK);
            if (OUT_VALID === 1'b1) begin
                check($sformatf("%s_byte%0d", name, i), 64'(OUT_DATA), 64'(exp_q[i]));
                if (OUT_READY) i++;
            end
            @(posedge CLK);
            #1;
            if (stall && i == 3 && stall_cnt < 5) begin
                OUT_READY = 1'b0;
                stall_cnt++;
            end else begin
                OUT_READY = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
        check({name, "_rx_count"}, 64'(i), 64'(NB));
        check({name, "_done_hi"}, 64'(DONE), 64'd1);
        check({name, "_busy_lo"}, 64'(BUSY), 64'd0);
        OUT_READY = 1'b0;
        @(posedge CLK);
        #1;
        check({name, "_done_lo"}, 64'(DONE), 64'd0);
        check({name, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
        $display("[TB] txn %s hdr=%02h steps=%0d lane0=%0d", name, hdr, act_q.size(), acc0);
    endtask

    initial begin
        int d0, len, mode;
        RESET     = 1'b1;
        IN_DATA   = 8'h00;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_in_ready", 64'(IN_READY), 64'd0);
        check("rst_out_valid", 64'(OUT_VALID), 64'd0);
        check("rst_out_data", 64'(OUT_DATA), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_done", 64'(DONE), 64'd0);
        check("rst_err", 64'(ERR), 64'd0);
        RESET = 1'b0;
        #1;
        check("idle_in_ready", 64'(IN_READY), 64'd1);

        // Signed basic: lanes 2,-7,-4,11.
        clear_q();
        push_step(3, 2, -1, 0, 5);
        push_step(-4, 1, 1, 1, 1);
        run_txn("signed_basic", 8'h02, 1'b0, 1'b0);

        // Unsigned vs signed interpretation of the same bytes.
        clear_q();
        push_step(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_txn("unsigned", 8'h41, 1'b0, 1'b0);
        run_txn("signed_ff", 8'h01, 1'b0, 1'b0);

        // ReLU: lane 0 reads 0 but the accumulator keeps -6.
        clear_q();
        push_step(-2, 3, -3, 0, 1);
        run_txn("relu", 8'h81, 1'b0, 1'b0);
        check("relu_acc0_probe", 64'(dut.acc_reg[0]), 64'(16'hFFFA));

        // Saturation with LEN=0 meaning 64 steps.
        clear_q();
        for (int s = 0; s < 64; s++) push_step(127, 127, 127, 127, 127);
        run_txn("sat_pos", 8'h00, 1'b0, 1'b0);
        clear_q();
        for (int s = 0; s < 64; s++) push_step(-128, 127, 127, 127, 127);
        run_txn("sat_neg", 8'h00, 1'b0, 1'b0);
        clear_q();
        for (int s = 0; s < 64; s++) push_step(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_txn("sat_uns", 8'h40, 1'b0, 1'b0);

        // Saturate then move back toward range.
        clear_q();
        for (int s = 0; s < 3; s++) push_step(127, 127, 127, 127, -128);
        push_step(-1, 127, 127, 127, 127);
        run_txn("sat_recover", 8'h04, 1'b0, 1'b0);

        // Handshake: random input gaps, random OUT_READY and a 5-cycle stall.
        clear_q();
        push_step(3, 2, -1, 0, 5);
        push_step(-4, 1, 1, 1, 1);
        run_txn("handshake", 8'h02, 1'b1, 1'b1);

        // Reserved mode header.
        send_byte(8'hC3, 1'b0);
        check("err_pulse", 64'(ERR), 64'd1);
        check("err_busy", 64'(BUSY), 64'd0);
        @(posedge CLK);
        #1;
        check("err_clear", 64'(ERR), 64'd0);
        check("err_idle_ready", 64'(IN_READY), 64'd1);
        clear_q();
        push_step(5, 1, 2, 3, 4);
        run_txn("after_err", 8'h01, 1'b0, 1'b0);

        // Reset in the middle of the weight phase.
        d0 = done_cnt;
        send_byte(8'h02, 1'b0);
        send_byte(8'h07, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h05, 1'b0);
        check("mid_busy", 64'(BUSY), 64'd1);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("midrst_in_ready", 64'(IN_READY), 64'd0);
        check("midrst_busy", 64'(BUSY), 64'd0);
        check("midrst_out_valid", 64'(OUT_VALID), 64'd0);
        check("midrst_acc0", 64'(dut.acc_reg[0]), 64'd0);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        clear_q();
        push_step(-7, 9, -9, 100, -100);
        run_txn("after_rst", 8'h01, 1'b0, 1'b0);

        // Random transactions across all valid modes.
        for (int t = 0; t < 12; t++) begin
            mode = $urandom_range(0, 2);
            len  = (t == 11) ? 64 : $urandom_range(1, 6);
            clear_q();
            for (int s = 0; s < len; s++)
                push_step($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 255), $urandom_range(0, 255));
            run_txn($sformatf("rand%0d", t), {2'(mode), 6'(len)}, t[0], t[1]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
